// File: rtl/jtframe_db9merge.sv
// rtl/jtframe_db9merge.sv - DB9/DB15 debounce, presence FSM, HPS merge and autofire
module jtframe_db9merge #(
  parameter int DBNC    = 3,
  parameter int IDLE_N  = 4,
  parameter int TIMEOUT = 20,
  parameter int AF_DIV  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cfg,
  input  logic        sample,
  input  logic        hooked,
  input  logic [11:0] db_joy0,
  input  logic [11:0] db_joy1,
  input  logic [11:0] hps_joy0,
  input  logic [11:0] hps_joy1,
  input  logic        af_en,
  input  logic [11:0] af_mask,
  output logic [11:0] joy0_out,
  output logic [11:0] joy1_out,
  output logic        db_active
);

  localparam logic [2:0] DBNC_V = 3'(DBNC);
  localparam logic [3:0] IDLE_V = 4'(IDLE_N);
  localparam logic [3:0] AF_TOP = 4'(AF_DIV - 1);

  typedef enum logic [1:0] {ST_OFF, ST_PROBE, ST_ACTIVE} state_t;

  state_t             r_state, w_state_nxt;
  logic [TIMEOUT-1:0] r_wd, w_wd_nxt;
  logic [3:0]         r_idle, w_idle_nxt;
  logic [11:0]        r_last [2];
  logic [11:0]        r_stable [2];
  logic [2:0]         r_cnt [2];
  logic [11:0]        w_last_nxt [2];
  logic [11:0]        w_stable_nxt [2];
  logic [2:0]         w_cnt_nxt [2];
  logic [11:0]        w_raw [2];
  logic [3:0]         r_af_cnt, w_af_cnt_nxt;
  logic               r_af_phase, w_af_phase_nxt;
  logic               w_wd_to, w_force_off;
  logic [11:0]        w_db0, w_db1, w_af_gate;

  always_comb begin
    w_wd_to     = &r_wd;
    w_force_off = (r_state != ST_OFF) && (!cfg[2] || !hooked || w_wd_to);
    w_wd_nxt    = sample ? '0 : (w_wd_to ? r_wd : r_wd + 1'b1);
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle;
    case (r_state)
      ST_OFF: begin
        w_idle_nxt = '0;
        // A saturated watchdog keeps us in OFF until a sample proves the scanner alive
        if (cfg[2] && hooked && !w_wd_to) w_state_nxt = ST_PROBE;
      end
      ST_PROBE: begin
        if (sample) begin
          if (db_joy0 == 12'd0) begin
            w_idle_nxt = r_idle + 4'd1;
            if (r_idle + 4'd1 == IDLE_V) w_state_nxt = ST_ACTIVE;
          end else begin
            w_idle_nxt = '0;
          end
        end
      end
      default: w_idle_nxt = '0;
    endcase
    if (w_force_off) begin
      w_state_nxt = ST_OFF;
      w_idle_nxt  = '0;
    end
  end

  always_comb begin
    w_raw[0] = db_joy0;
    w_raw[1] = db_joy1;
    for (int p = 0; p < 2; p++) begin
      w_last_nxt[p]   = r_last[p];
      w_cnt_nxt[p]    = r_cnt[p];
      w_stable_nxt[p] = r_stable[p];
      if (w_state_nxt == ST_OFF) begin
        w_last_nxt[p]   = '0;
        w_cnt_nxt[p]    = '0;
        w_stable_nxt[p] = '0;
      end else if (sample && r_state != ST_OFF) begin
        if (w_raw[p] != r_last[p]) begin
          w_last_nxt[p] = w_raw[p];
          w_cnt_nxt[p]  = 3'd1;
          if (DBNC_V == 3'd1) w_stable_nxt[p] = w_raw[p];
        end else if (r_cnt[p] < DBNC_V) begin
          w_cnt_nxt[p] = r_cnt[p] + 3'd1;
          if (r_cnt[p] + 3'd1 == DBNC_V) w_stable_nxt[p] = w_raw[p];
        end
      end
    end
  end

  always_comb begin
    w_af_cnt_nxt   = r_af_cnt;
    w_af_phase_nxt = r_af_phase;
    if (!af_en) begin
      w_af_cnt_nxt   = '0;
      w_af_phase_nxt = 1'b1;
    end else if (sample) begin
      if (r_af_cnt == AF_TOP) begin
        w_af_cnt_nxt   = '0;
        w_af_phase_nxt = ~r_af_phase;
      end else begin
        w_af_cnt_nxt = r_af_cnt + 4'd1;
      end
    end
    // Outputs are built from next-cycle values so they line up with db_active
    w_db0     = (w_state_nxt == ST_ACTIVE) ? w_stable_nxt[0] : 12'd0;
    w_db1     = (w_state_nxt == ST_ACTIVE && cfg[0]) ? w_stable_nxt[1] : 12'd0;
    w_af_gate = af_mask & {12{af_en & ~w_af_phase_nxt}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_OFF;
      r_wd       <= '0;
      r_idle     <= '0;
      r_af_cnt   <= '0;
      r_af_phase <= 1'b1;
      joy0_out   <= '0;
      joy1_out   <= '0;
      for (int p = 0; p < 2; p++) begin
        r_last[p]   <= '0;
        r_cnt[p]    <= '0;
        r_stable[p] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_wd       <= w_wd_nxt;
      r_idle     <= w_idle_nxt;
      r_af_cnt   <= w_af_cnt_nxt;
      r_af_phase <= w_af_phase_nxt;
      joy0_out   <= (hps_joy0 | w_db0) & ~w_af_gate;
      joy1_out   <= (hps_joy1 | w_db1) & ~w_af_gate;
      for (int p = 0; p < 2; p++) begin
        r_last[p]   <= w_last_nxt[p];
        r_cnt[p]    <= w_cnt_nxt[p];
        r_stable[p] <= w_stable_nxt[p];
      end
    end
  end

  assign db_active = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_jtframe_db9merge.sv
// tb/tb_jtframe_db9merge.sv - self-checking bench for jtframe_db9merge
module tb_jtframe_db9merge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  cfg = 3'b000;
  logic        sample = 1'b0;
  logic        hooked = 1'b0;
  logic [11:0] db_joy0 = '0, db_joy1 = '0, hps_joy0 = '0, hps_joy1 = '0;
  logic        af_en = 1'b0;
  logic [11:0] af_mask = '0;
  logic [11:0] joy0_out, joy1_out;
  logic        db_active;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jtframe_db9merge #(.DBNC(3), .IDLE_N(4), .TIMEOUT(8), .AF_DIV(4)) dut (
    .clk(clk), .rst(rst), .cfg(cfg), .sample(sample), .hooked(hooked),
    .db_joy0(db_joy0), .db_joy1(db_joy1), .hps_joy0(hps_joy0), .hps_joy1(hps_joy1),
    .af_en(af_en), .af_mask(af_mask),
    .joy0_out(joy0_out), .joy1_out(joy1_out), .db_active(db_active)
  );

  typedef struct {
    string       name;
    logic [2:0]  cfg;
    logic        hooked;
    logic [11:0] db0, db1, hps0, hps1;
    logic        af;
    logic [11:0] mask, e0, e1;
    logic        eact;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic void add(input string n, input logic [2:0] c, input logic h,
                              input logic [11:0] d0, input logic [11:0] d1,
                              input logic [11:0] h0, input logic [11:0] h1,
                              input logic af, input logic [11:0] m,
                              input logic [11:0] e0, input logic [11:0] e1, input logic a);
    vec_t v;
    v.name = n; v.cfg = c; v.hooked = h; v.db0 = d0; v.db1 = d1; v.hps0 = h0; v.hps1 = h1;
    v.af = af; v.mask = m; v.e0 = e0; v.e1 = e1; v.eact = a;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, want);
    end
  endtask

  task automatic run_row(input vec_t v);
    vec_t e;
    @(posedge clk); #1;
    cfg = v.cfg; hooked = v.hooked; db_joy0 = v.db0; db_joy1 = v.db1;
    hps_joy0 = v.hps0; hps_joy1 = v.hps1; af_en = v.af; af_mask = v.mask;
    sample = 1'b1;
    exp_q.push_back(v);
    @(posedge clk); #1;
    sample = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (joy0_out !== e.e0 || joy1_out !== e.e1 || db_active !== e.eact) begin
      errors++;
      $display("FAIL %s: got joy0=%h joy1=%h act=%b expected joy0=%h joy1=%h act=%b",
               e.name, joy0_out, joy1_out, db_active, e.e0, e.e1, e.eact);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse(input logic [11:0] d0);
    @(posedge clk); #1;
    db_joy0 = d0;
    sample = 1'b1;
    @(posedge clk); #1;
    sample = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    // probe: four idle samples bring the port up
    for (int i = 0; i < 3; i++) add("probe_idle", 3'b101, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add("probe_active", 3'b101, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // debounce of player 0 and glitch rejection
    add("db0_s1", 3'b101, 1, 12'h010, 0, 0, 0, 0, 0, 0, 0, 1);
    add("db0_s2", 3'b101, 1, 12'h010, 0, 0, 0, 0, 0, 0, 0, 1);
    add("db0_s3", 3'b101, 1, 12'h010, 0, 0, 0, 0, 0, 12'h010, 0, 1);
    add("glitch_0", 3'b101, 1, 12'h000, 0, 0, 0, 0, 0, 12'h010, 0, 1);
    add("glitch_1", 3'b101, 1, 12'h010, 0, 0, 0, 0, 0, 12'h010, 0, 1);
    add("glitch_2", 3'b101, 1, 12'h010, 0, 0, 0, 0, 0, 12'h010, 0, 1);
    // player 1 masked by cfg[0]
    for (int i = 0; i < 3; i++)
      add("db1_masked", 3'b100, 1, 12'h010, 12'h001, 0, 12'h100, 0, 0, 12'h010, 12'h100, 1);
    add("db1_enabled", 3'b101, 1, 12'h010, 12'h001, 0, 12'h100, 0, 0, 12'h010, 12'h101, 1);
    // autofire: 4 samples per half period, starting high
    for (int i = 0; i < 9; i++)
      add("autofire", 3'b101, 1, 12'h010, 12'h001, 12'h810, 12'h100, 1, 12'h010,
          (i >= 3 && i <= 6) ? 12'h800 : 12'h810, 12'h101, 1);
    for (int i = 0; i < 2; i++)
      add("af_off", 3'b101, 1, 12'h010, 12'h001, 12'h810, 12'h100, 0, 12'h010, 12'h810, 12'h101, 1);
    // hooked drops with a new value on the same sample
    add("unhook", 3'b101, 0, 12'h020, 12'h001, 12'h810, 12'h100, 0, 0, 12'h810, 12'h100, 0);
    add("rehook", 3'b101, 1, 12'h020, 12'h001, 12'h810, 12'h100, 0, 0, 12'h810, 12'h100, 0);
    for (int i = 0; i < 2; i++)
      add("probe_busy", 3'b101, 1, 12'h020, 12'h001, 12'h810, 12'h100, 0, 0, 12'h810, 12'h100, 0);
    for (int i = 0; i < 3; i++)
      add("reprobe_idle", 3'b101, 1, 0, 12'h001, 12'h810, 12'h100, 0, 0, 12'h810, 12'h100, 0);
    add("reprobe_active", 3'b101, 1, 0, 12'h001, 12'h810, 12'h100, 0, 0, 12'h810, 12'h101, 1);
    add("reactive_hold", 3'b101, 1, 0, 12'h001, 12'h810, 12'h100, 0, 0, 12'h810, 12'h101, 1);

    #2 rst = 1'b1;
    #1;
    chk("reset_joy0", 32'(joy0_out), 32'h0);
    chk("reset_joy1", 32'(joy1_out), 32'h0);
    chk("reset_active", 32'(db_active), 32'h0);
    cfg = 3'b101; hooked = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    foreach (tbl[i]) run_row(tbl[i]);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    // watchdog: no samples, must not trip early, must trip within the bound
    repeat (200) @(posedge clk);
    #1 chk("wd_not_early", 32'(db_active), 32'h1);
    n = 0;
    while (db_active && n < 150) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wd_timeout", 32'(db_active), 32'h0);
    chk("wd_joy0_hps", 32'(joy0_out), 32'h810);
    chk("wd_joy1_hps", 32'(joy1_out), 32'h100);
    for (int i = 0; i < 3; i++) pulse(12'h000);
    chk("wd_resume_probe", 32'(db_active), 32'h0);
    for (int i = 0; i < 3; i++) pulse(12'h000);
    chk("wd_resume_active", 32'(db_active), 32'h1);
    chk("wd_resume_joy1", 32'(joy1_out), 32'h101);

    // asynchronous reset mid-operation
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("midrst_joy0", 32'(joy0_out), 32'h0);
    chk("midrst_joy1", 32'(joy1_out), 32'h0);
    chk("midrst_active", 32'(db_active), 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("postrst_hps", 32'(joy0_out), 32'h810);
    for (int i = 0; i < 3; i++) pulse(12'h000);
    chk("postrst_probe", 32'(db_active), 32'h0);
    pulse(12'h000);
    chk("postrst_active", 32'(db_active), 32'h1);
    chk("postrst_joy1", 32'(joy1_out), 32'h101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtframe_db9merge.md
Name: jtframe_db9merge

Overview:
Downstream consumer of the DB9/DB15 joystick scanner. Takes the scanner's 12-bit sorted player vectors, its sample strobe and hooked flag, and debounces the DB9 data. Tracks controller presence with a small FSM, then merges the result with the HPS/USB joystick vectors and applies optional autofire. Outputs feed the core's game input logic directly.

Parameters:
DBNC, 3, consecutive identical sample strobes required before a DB vector is accepted (1..7)
IDLE_N, 4, consecutive all-zero DB player-0 samples required in PROBE before going ACTIVE (1..15)
TIMEOUT, 20, width of the sample watchdog counter; timeout fires at 2^TIMEOUT-1 clk cycles without a sample
AF_DIV, 4, autofire half-period in sample strobes (1..15)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cfg  in  3  [2] DB9 enable, [1] DB15 enable (informative only, not used for gating), [0] 2-player DB support
sample  in  1  one-clk strobe from scanner; db_joy0/db_joy1 valid in that cycle
hooked  in  1  scanner hooked flag
db_joy0  in  12  DB player 0 vector, active-high
db_joy1  in  12  DB player 1 vector, active-high
hps_joy0  in  12  HPS player 0 vector, active-high
hps_joy1  in  12  HPS player 1 vector, active-high
af_en  in  1  autofire enable
af_mask  in  12  bits subject to autofire
joy0_out  out  12  merged player 0, registered
joy1_out  out  12  merged player 1, registered
db_active  out  1  FSM in ACTIVE

Behaviour:
- Reset state: joy0_out=0, joy1_out=0, db_active=0, FSM=OFF, stable vectors=0, all counters=0, af_phase=1.
- Debounce, independent per player, evaluated only on sample=1:
  - raw differs from last_raw: last_raw<=raw, cnt<=1.
  - raw equals last_raw and cnt<DBNC: cnt<=cnt+1.
  - Accept: the sample that makes cnt reach DBNC loads stable<=raw; cnt saturates at DBNC.
  - With DBNC=1, every sample loads stable.
- Watchdog: counter clears on sample and counts up otherwise. Reaching all-ones forces FSM to OFF and saturates the counter.
- FSM:
  - OFF -> PROBE: cfg[2]=1 and hooked=1. Idle counter is cleared on entry.
  - PROBE: on each sample, db_joy0==0 increments the idle counter; any nonzero value clears it. The idle counter reaching IDLE_N -> ACTIVE.
  - Any state except OFF -> OFF when cfg[2]=0, hooked=0, or watchdog timeout. This exit has priority over every other transition in the same cycle.
  - Entering OFF clears the stable vectors and debounce counters.
- Masking: db0 = ACTIVE ? stable0 : 0; db1 = (ACTIVE && cfg[0]) ? stable1 : 0.
- Merge: mN = hps_joyN | dbN.
- Autofire:
  - af_cnt increments on each sample while af_en=1. When it reaches AF_DIV-1 it wraps to 0 and toggles af_phase.
  - af_en=0 holds af_cnt=0 and af_phase=1.
  - joyN_out <= mN & ~(af_mask & {12{af_en & ~af_phase}}).
- Latency:
  - hps inputs reach the outputs 1 clk later.
  - A DB change appears 1 clk after the sample that makes it stable, i.e. DBNC samples after the first occurrence.
  - A DB1 change and DB0 change are handled identically.
- Simultaneous events:
  - sample in the same cycle as a forced OFF: the sample is discarded and stable is cleared.
  - A sample in PROBE also feeds the debouncer, so stable data is ready when ACTIVE is entered.
- Reset mid-operation: returns immediately to the reset state. There is no memory of the prior presence state.

Test Plan:
- Reset, cfg=3'b101, hooked=1, db_joy0=0, 4 samples -> db_active=1 on the clk after the 4th sample; outputs still 0.
- ACTIVE, db_joy0=12'h010 for 3 samples -> joy0_out=12'h010 1 clk after the 3rd sample. Glitch pattern 010,000,010 -> no change.
- ACTIVE, cfg[0]=0, db_joy1=12'h001 stable, hps_joy1=12'h100 -> joy1_out=12'h100. Set cfg[0]=1 -> joy1_out=12'h101.
- ACTIVE, hooked drops in the same cycle as a sample carrying 12'h020 -> db_active=0 next clk, joy0_out=hps only, and 12'h020 is never output.
- Stop sample strobes for 2^20-1 clks -> db_active=0. Resuming samples re-enters PROBE and requires IDLE_N idle samples.
- af_en=1, af_mask=12'h010, hps_joy0=12'h010 held -> joy0_out bit4 toggles every 4 samples, starting high. af_en=0 -> bit4 steady high.
